// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns pcF, issues credit-limited fetches, buffers
// returned instructions and drives the IF/ID pipeline register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        pcsrcE,
    input  logic [31:0] pctargetE,
    input  logic        stallD,
    input  logic        flushD,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic [31:0] pcplus4D,
    output logic        validD
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    // Stale responses can span two redirect windows, so discard gets one extra bit.
    localparam int DW = CW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    logic [31:0]   pcF_q, pcF_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [DW-1:0] discard_q, discard_d;
    logic [CW-1:0] fifoCount_q, fifoCount_d;
    logic [AW-1:0] fifoHead_q, fifoHead_d, fifoTail_q, fifoTail_d;
    logic [AW-1:0] pcqHead_q, pcqHead_d, pcqTail_q, pcqTail_d;
    logic [31:0]   instrD_q, instrD_d, pcD_q, pcD_d;
    logic          validD_q, validD_d;

    logic [31:0]   fifoInstr_q [BUF_DEPTH];
    logic [31:0]   fifoPc_q    [BUF_DEPTH];
    logic [31:0]   pcq_q       [BUF_DEPTH];

    logic [CW-1:0] creditsUsed;
    logic          reqFire, rspTake, loadD, fifoEmpty, bypass, push, pop;
    logic [31:0]   rspPc;

    assign creditsUsed    = fifoCount_q + outstanding_q;
    assign imem_req_valid = reset_n && (creditsUsed < DEPTH_C) && !pcsrcE;
    assign imem_req_addr  = pcF_q;

    assign reqFire   = imem_req_valid && imem_req_ready;
    assign rspTake   = imem_rsp_valid && (discard_q == '0);
    assign loadD     = !stallD && !flushD && !pcsrcE;
    assign fifoEmpty = (fifoCount_q == '0);
    assign bypass    = rspTake && fifoEmpty && loadD;
    assign push      = rspTake && !bypass && !pcsrcE;
    assign pop       = loadD && !fifoEmpty;
    assign rspPc     = pcq_q[pcqHead_q];

    assign instrD   = instrD_q;
    assign pcD      = pcD_q;
    assign pcplus4D = pcD_q + 32'd4;
    assign validD   = validD_q;

    always_comb begin
        pcF_d         = pcF_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        fifoCount_d   = fifoCount_q;
        fifoHead_d    = fifoHead_q;
        fifoTail_d    = fifoTail_q;
        pcqHead_d     = pcqHead_q;
        pcqTail_d     = pcqTail_q;
        instrD_d      = instrD_q;
        pcD_d         = pcD_q;
        validD_d      = validD_q;

        if (pcsrcE) begin
            pcF_d         = pctargetE;
            discard_d     = discard_q + DW'(outstanding_q) - DW'(imem_rsp_valid);
            outstanding_d = '0;
            fifoCount_d   = '0;
            fifoHead_d    = '0;
            fifoTail_d    = '0;
            pcqHead_d     = '0;
            pcqTail_d     = '0;
        end else begin
            if (reqFire) begin
                pcF_d     = pcF_q + 32'd4;
                pcqTail_d = pcqTail_q + AW'(1);
            end
            if (rspTake) begin
                pcqHead_d = pcqHead_q + AW'(1);
            end
            if (imem_rsp_valid && !rspTake) begin
                discard_d = discard_q - DW'(1);
            end
            outstanding_d = outstanding_q + CW'(reqFire) - CW'(rspTake);
            fifoCount_d   = fifoCount_q + CW'(push) - CW'(pop);
            if (push) begin
                fifoTail_d = fifoTail_q + AW'(1);
            end
            if (pop) begin
                fifoHead_d = fifoHead_q + AW'(1);
            end
        end

        if (pcsrcE || flushD || (loadD && fifoEmpty && !rspTake)) begin
            instrD_d = NOP;
            pcD_d    = '0;
            validD_d = 1'b0;
        end else if (pop) begin
            instrD_d = fifoInstr_q[fifoHead_q];
            pcD_d    = fifoPc_q[fifoHead_q];
            validD_d = 1'b1;
        end else if (bypass) begin
            instrD_d = imem_rsp_data;
            pcD_d    = rspPc;
            validD_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcF_q         <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            fifoCount_q   <= '0;
            fifoHead_q    <= '0;
            fifoTail_q    <= '0;
            pcqHead_q     <= '0;
            pcqTail_q     <= '0;
            instrD_q      <= NOP;
            pcD_q         <= '0;
            validD_q      <= 1'b0;
        end else begin
            pcF_q         <= pcF_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            fifoCount_q   <= fifoCount_d;
            fifoHead_q    <= fifoHead_d;
            fifoTail_q    <= fifoTail_d;
            pcqHead_q     <= pcqHead_d;
            pcqTail_q     <= pcqTail_d;
            instrD_q      <= instrD_d;
            pcD_q         <= pcD_d;
            validD_q      <= validD_d;
        end
    end

    // Storage arrays need no reset: the pointers and counts define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoInstr_q[fifoTail_q] <= imem_rsp_data;
            fifoPc_q[fifoTail_q]    <= rspPc;
        end
        if (reqFire) begin
            pcq_q[pcqTail_q] <= pcF_q;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: a behavioural memory and a
// queue-based fetch model predict every request and every IF/ID value.
module tb_fetch_stage;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        pcsrcE = 1'b0, stallD = 1'b0, flushD = 1'b0;
    logic [31:0] pctargetE = '0;
    logic [31:0] instrD, pcD, pcplus4D;
    logic        validD;

    fetch_stage #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .pcsrcE(pcsrcE), .pctargetE(pctargetE),
        .stallD(stallD), .flushD(flushD),
        .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D), .validD(validD)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] data; } item_t;
    typedef struct { logic [31:0] data; int epoch; int due; } memEntry_t;

    item_t       sbq[$];
    memEntry_t   memq[$];
    int          errors = 0, checks = 0;
    int          arrived = 0, epoch = 0, cycle = 0, memLat = 1, lastDue = -1;
    logic [31:0] modelPc = RST_PC, dataMask = '0;
    bit          lastLoad = 1'b0, lastBubble = 1'b1;
    logic        expValidD = 1'b0;
    logic [31:0] expInstr = NOP, expPc = '0;
    item_t       head;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        checkOutput("rst_req_addr", imem_req_addr, RST_PC);
        checkOutput("rst_instrD", instrD, NOP);
        checkOutput("rst_pcD", pcD, 32'd0);
        checkOutput("rst_pcplus4D", pcplus4D, 32'd4);
        checkOutput("rst_validD", {31'b0, validD}, 32'd0);
    endtask

    task automatic applyStimulus(input bit stall, input bit flush, input bit redir,
                                 input logic [31:0] tgt, input bit rdy, input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            stallD         = stall;
            flushD         = flush;
            pcsrcE         = redir;
            pctargetE      = tgt;
            imem_req_ready = rdy;
        end
    endtask

    // Memory and fetch model: the queue holds every fetched-but-undelivered
    // instruction; its length is the credit count that gates new requests.
    always @(posedge clk) begin : modelBlk
        bit accept;
        int due;
        cycle++;
        if (!reset_n) begin
            sbq.delete();
            memq.delete();
            arrived    = 0;
            epoch++;
            modelPc    = RST_PC;
            lastLoad   = 1'b0;
            lastBubble = 1'b1;
            lastDue    = -1;
        end else begin
            accept = (sbq.size() < DEPTH) && !pcsrcE && imem_req_ready;
            if (imem_rsp_valid && memq.size() > 0) begin
                if (memq[0].epoch == epoch) arrived++;
                void'(memq.pop_front());
            end
            lastBubble = pcsrcE || flushD;
            lastLoad   = !stallD && !flushD && !pcsrcE;
            if (accept) begin
                due = cycle + memLat - 1;
                if (due <= lastDue) due = lastDue + 1;
                lastDue = due;
                sbq.push_back('{pc: modelPc, data: modelPc ^ dataMask});
                memq.push_back('{data: modelPc ^ dataMask, epoch: epoch, due: due});
                modelPc = modelPc + 32'd4;
            end
            if (pcsrcE) begin
                sbq.delete();
                arrived = 0;
                epoch++;
                modelPc = pctargetE;
            end
        end
        #1;
        if (reset_n && memq.size() > 0 && memq[0].due <= cycle) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memq[0].data;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Monitor: decides what IF/ID must now show and pops the scoreboard on delivery.
    always @(negedge clk) begin
        if (reset_n) begin
            if (lastBubble || (lastLoad && arrived == 0)) begin
                expValidD = 1'b0;
                expInstr  = NOP;
                expPc     = '0;
            end else if (lastLoad && sbq.size() > 0) begin
                head = sbq.pop_front();
                arrived--;
                expValidD = 1'b1;
                expInstr  = head.data;
                expPc     = head.pc;
            end
            checkOutput("validD", {31'b0, validD}, {31'b0, expValidD});
            checkOutput("instrD", instrD, expInstr);
            checkOutput("pcD", pcD, expPc);
            checkOutput("pcplus4D", pcplus4D, expPc + 32'd4);
            checkOutput("req_valid", {31'b0, imem_req_valid},
                        {31'b0, (sbq.size() < DEPTH) && !pcsrcE});
            checkOutput("req_addr", imem_req_addr, modelPc);
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #2;
        checkResetOutputs();
        @(posedge clk);
        #3;
        reset_n = 1'b1;

        applyStimulus(0, 0, 0, '0, 1, 12);
        applyStimulus(1, 0, 0, '0, 1, 3);
        applyStimulus(0, 0, 0, '0, 1, 8);

        memLat = 3;
        applyStimulus(0, 0, 0, '0, 1, 6);
        applyStimulus(0, 0, 1, 32'h100, 1, 1);
        applyStimulus(0, 0, 0, '0, 1, 12);

        memLat = 1;
        applyStimulus(0, 1, 0, '0, 1, 1);
        applyStimulus(0, 0, 0, '0, 1, 6);
        applyStimulus(0, 0, 0, '0, 0, 4);
        applyStimulus(0, 0, 0, '0, 1, 6);

        dataMask = 32'hC0DE_0000;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 49) == 0) memLat = $urandom_range(1, 3);
            applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 19) == 0, $urandom & 32'hFFFF_FFFC,
                          $urandom_range(0, 3) != 0, 1);
        end

        applyStimulus(0, 0, 0, '0, 1, 4);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checkResetOutputs();
        dataMask = '0;
        memLat   = 1;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        applyStimulus(0, 0, 0, '0, 1, 10);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
